// File: rtl/enemy_pkg.sv
// Shared constants and types for the enemy collision path: edge/direction
// codes, default sprite geometry and the collision FSM state type.
package enemy_pkg;

    // One-hot edge codes; the motion FSM uses the same encoding for direction.
    localparam logic [3:0] TOP    = 4'b0100;
    localparam logic [3:0] RIGHT  = 4'b0010;
    localparam logic [3:0] LEFT   = 4'b1000;
    localparam logic [3:0] BOTTOM = 4'b0001;
    localparam logic [3:0] NONE   = 4'b0000;

    localparam int SPRITE_WIDTH  = 32;
    localparam int SPRITE_HEIGHT = 32;
    localparam int EDGE_DEPTH    = 8;
    localparam int KILL_COUNT    = 16;

    localparam int KILL_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE_ST    = 2'd0,
        SCAN_ST    = 2'd1,
        LATCHED_ST = 2'd2,
        DEAD_ST    = 2'd3
    } state_t;

endpackage

// File: rtl/edge_code_calc.sv
// Combinational edge classifier: which edge band of the sprite the current
// pixel lies in, masked by the direction of motion (one-hot result).
module edge_code_calc
    import enemy_pkg::*;
#(
    parameter int WIDTH     = SPRITE_WIDTH,
    parameter int HEIGHT    = SPRITE_HEIGHT,
    parameter int EDGE_BAND = EDGE_DEPTH
) (
    input  logic [10:0]        pixel_x,
    input  logic [10:0]        pixel_y,
    input  logic signed [10:0] top_left_x,
    input  logic signed [10:0] top_left_y,
    input  logic [3:0]         direction,
    output logic [3:0]         code
);

    localparam logic [10:0] W_LIM   = 11'(WIDTH);
    localparam logic [10:0] H_LIM   = 11'(HEIGHT);
    localparam logic [10:0] BAND    = 11'(EDGE_BAND);
    localparam logic [10:0] R_START = 11'(WIDTH - EDGE_BAND);
    localparam logic [10:0] B_START = 11'(HEIGHT - EDGE_BAND);

    logic [10:0] off_x;
    logic [10:0] off_y;
    logic        in_x;
    logic        in_y;
    logic [3:0]  raw;

    // Two's-complement wrap gives the signed offset; bit 10 is its sign.
    assign off_x = pixel_x - $unsigned(top_left_x);
    assign off_y = pixel_y - $unsigned(top_left_y);

    assign in_x = !off_x[10] && (off_x < W_LIM);
    assign in_y = !off_y[10] && (off_y < H_LIM);

    // NOTE: every combinationally assigned variable gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        raw = NONE;
        if (in_x && in_y) begin
            if (off_x <  BAND)    raw = raw | LEFT;
            if (off_x >= R_START) raw = raw | RIGHT;
            if (off_y <  BAND)    raw = raw | TOP;
            if (off_y >= B_START) raw = raw | BOTTOM;
        end
    end

    assign code = raw & direction;

endmodule

// File: rtl/enemy_collision_detector.sv
// Per-frame collision front end for one enemy: first blocking wall hit of a
// frame (pulse + held edge code) and a sticky kill flag from explosion overlap.
module enemy_collision_detector
    import enemy_pkg::*;
#(
    parameter int OBJECT_WIDTH_X = SPRITE_WIDTH,
    parameter int OBJECT_HIGHT_Y = SPRITE_HEIGHT,
    parameter int EDGE_BAND      = EDGE_DEPTH,
    parameter int KILL_PIXELS    = KILL_COUNT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               game_on,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    input  logic [3:0]         direction,
    input  logic               enemyDR,
    input  logic               wallDR,
    input  logic               explosionDR,
    output logic               collision,
    output logic [3:0]         HitEdgeCode,
    output logic               enemy_killed
);

    localparam logic [KILL_CNT_W-1:0] KILL_LIMIT = KILL_CNT_W'(KILL_PIXELS);
    localparam logic [KILL_CNT_W-1:0] CNT_MAX    = '1;

    logic [3:0] edge_code;

    edge_code_calc #(
        .WIDTH     (OBJECT_WIDTH_X),
        .HEIGHT    (OBJECT_HIGHT_Y),
        .EDGE_BAND (EDGE_BAND)
    ) u_edge_code_calc (
        .pixel_x    (pixelX),
        .pixel_y    (pixelY),
        .top_left_x (topLeftX),
        .top_left_y (topLeftY),
        .direction  (direction),
        .code       (edge_code)
    );

    logic       enemy_q;
    logic       wall_q;
    logic       expl_q;
    logic [3:0] code_q;

    state_t                state;
    logic [KILL_CNT_W-1:0] kill_cnt;

    logic                  block_hit_q;
    logic                  expl_hit_q;
    logic [KILL_CNT_W-1:0] kill_cnt_next;
    logic                  kill_reached;

    assign block_hit_q = enemy_q && wall_q && (code_q != NONE);
    assign expl_hit_q  = enemy_q && expl_q;

    always_comb begin
        kill_cnt_next = kill_cnt;
        if (expl_hit_q && (kill_cnt != CNT_MAX))
            kill_cnt_next = kill_cnt + 1'b1;
    end

    assign kill_reached = (kill_cnt_next >= KILL_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            enemy_q      <= 1'b0;
            wall_q       <= 1'b0;
            expl_q       <= 1'b0;
            code_q       <= NONE;
            state        <= IDLE_ST;
            kill_cnt     <= '0;
            collision    <= 1'b0;
            HitEdgeCode  <= NONE;
            enemy_killed <= 1'b0;
        end else begin
            enemy_q   <= enemyDR;
            wall_q    <= wallDR;
            expl_q    <= explosionDR;
            code_q    <= edge_code;
            collision <= 1'b0;

            if (!game_on) begin
                state        <= IDLE_ST;
                kill_cnt     <= '0;
                HitEdgeCode  <= NONE;
                enemy_killed <= 1'b0;
            end else begin
                unique case (state)
                    IDLE_ST: begin
                        kill_cnt    <= '0;
                        HitEdgeCode <= NONE;
                        state       <= SCAN_ST;
                    end

                    SCAN_ST, LATCHED_ST: begin
                        // Frame boundary discards whatever pixel is in the stage.
                        if (startOfFrame) begin
                            kill_cnt    <= '0;
                            HitEdgeCode <= NONE;
                            state       <= SCAN_ST;
                        end else if (kill_reached) begin
                            kill_cnt     <= kill_cnt_next;
                            HitEdgeCode  <= NONE;
                            enemy_killed <= 1'b1;
                            state        <= DEAD_ST;
                        end else begin
                            kill_cnt <= kill_cnt_next;
                            if (state == SCAN_ST && block_hit_q) begin
                                collision   <= 1'b1;
                                HitEdgeCode <= code_q;
                                state       <= LATCHED_ST;
                            end
                        end
                    end

                    DEAD_ST: begin
                        HitEdgeCode <= NONE;
                    end

                    default: begin
                        state <= IDLE_ST;
                    end
                endcase
            end
        end
    end

    hit_code_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(HitEdgeCode));

    pulse_only_on_entry: assert property (@(posedge clk) disable iff (reset)
        collision |-> (state == LATCHED_ST) && (HitEdgeCode != NONE));

endmodule
